// File: rtl/pipe_stage_reg.sv
// Reusable inter-stage pipeline register: valid/ready handshake, 2-entry skid buffer,
// flush, and a writeback-forwarding tap taken straight from the output entry.
//
// state | meaning
// EMPTY | no entry held, out_valid=0
// ONE   | main entry valid, skid empty
// FULL  | main and skid both valid, in_ready=0
module pipe_stage_reg #(
    parameter int                 DATA_W     = 32,
    parameter int                 RD_W       = 5,
    parameter int                 CTRL_W     = 2,
    parameter logic [CTRL_W-1:0]  CTRL_RESET = {CTRL_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RD_W-1:0]   in_rd_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RD_W-1:0]   out_rd_addr,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              fwd_hit,
    output logic [RD_W-1:0]   fwd_rd_addr,
    output logic [DATA_W-1:0] fwd_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic              main_valid;
    logic              skid_valid;
    logic              in_fire;
    logic              out_fire;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;

    logic [RD_W-1:0]   skid_rd_addr;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_fire) state_next = ONE;
                ONE: begin
                    if (in_fire && !out_fire)      state_next = FULL;
                    else if (!in_fire && out_fire) state_next = EMPTY;
                end
                FULL: if (out_fire) state_next = ONE;
                default: state_next = EMPTY;
            endcase
        end
    end

    // in_ready looks only at registered state and rst, so no combinational path from out_ready.
    always_comb begin
        main_valid     = (state == ONE) || (state == FULL);
        skid_valid     = (state == FULL);
        in_ready       = !rst && !skid_valid;
        out_valid      = main_valid;
        in_fire        = in_valid && in_ready;
        out_fire       = main_valid && out_ready;
        load_main_in   = !flush && in_fire && ((state == EMPTY) || ((state == ONE) && out_fire));
        load_skid      = !flush && in_fire && (state == ONE) && !out_fire;
        load_main_skid = !flush && (state == FULL) && out_fire;
    end

    // Payload registers only move on real transfers; flush leaves stale values in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_rd_addr  <= '0;
            out_data     <= '0;
            out_ctrl     <= CTRL_RESET;
            skid_rd_addr <= '0;
            skid_data    <= '0;
            skid_ctrl    <= '0;
        end else begin
            if (load_main_in) begin
                out_rd_addr <= in_rd_addr;
                out_data    <= in_data;
                out_ctrl    <= in_ctrl;
            end else if (load_main_skid) begin
                out_rd_addr <= skid_rd_addr;
                out_data    <= skid_data;
                out_ctrl    <= skid_ctrl;
            end
            if (load_skid) begin
                skid_rd_addr <= in_rd_addr;
                skid_data    <= in_data;
                skid_ctrl    <= in_ctrl;
            end
        end
    end

    assign fwd_hit     = main_valid && out_ctrl[0] && (out_rd_addr != '0);
    assign fwd_rd_addr = out_rd_addr;
    assign fwd_data    = out_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, then a random
// valid/ready/flush run scored against a reference queue.
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd_addr;
    logic [31:0] in_data;
    logic [1:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd_addr;
    logic [31:0] out_data;
    logic [1:0]  out_ctrl;
    logic        fwd_hit;
    logic [4:0]  fwd_rd_addr;
    logic [31:0] fwd_data;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rd_addr  (in_rd_addr),
        .in_data     (in_data),
        .in_ctrl     (in_ctrl),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rd_addr (out_rd_addr),
        .out_data    (out_data),
        .out_ctrl    (out_ctrl),
        .fwd_hit     (fwd_hit),
        .fwd_rd_addr (fwd_rd_addr),
        .fwd_data    (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are held across one rising edge; expectations are the outputs just after it.
    typedef struct {
        logic        rst;
        logic        flush;
        logic        iv;
        logic [4:0]  ird;
        logic [31:0] idat;
        logic [1:0]  ictl;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic [4:0]  e_rd;
        logic [31:0] e_dat;
        logic [1:0]  e_ctl;
        logic        e_fwd;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic f, input logic iv, input logic [4:0] ird,
                       input logic [31:0] idat, input logic [1:0] ictl, input logic ordy,
                       input logic e_ov, input logic e_ir, input logic [4:0] e_rd,
                       input logic [31:0] e_dat, input logic [1:0] e_ctl, input logic e_fwd);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.ird = ird; v.idat = idat; v.ictl = ictl;
        v.ordy = ordy; v.e_ov = e_ov; v.e_ir = e_ir; v.e_rd = e_rd; v.e_dat = e_dat;
        v.e_ctl = e_ctl; v.e_fwd = e_fwd;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    initial begin
        logic [31:0] ref_q[$];
        logic [31:0] exp_d;
        logic        fi;
        logic        fo;
        int          seq;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_rd_addr = '0;
        in_data = '0; in_ctrl = '0; out_ready = 1'b0;

        //   rst f iv rd  data          ctl ordy | ov ir rd  data          ctl fwd
        // reset with in_valid high
        add(1, 0, 1, 5'd9, 32'h99,      2'd1, 0,   0, 0, 5'd0, 32'h0,      2'd0, 0);
        add(1, 0, 1, 5'd9, 32'h99,      2'd1, 0,   0, 0, 5'd0, 32'h0,      2'd0, 0);
        add(0, 0, 0, 5'd0, 32'h0,       2'd0, 1,   0, 1, 5'd0, 32'h0,      2'd0, 0);
        // streaming
        add(0, 0, 1, 5'd1, 32'h11,      2'd1, 1,   1, 1, 5'd1, 32'h11,     2'd1, 1);
        add(0, 0, 1, 5'd2, 32'h22,      2'd0, 1,   1, 1, 5'd2, 32'h22,     2'd0, 0);
        add(0, 0, 1, 5'd3, 32'h33,      2'd1, 1,   1, 1, 5'd3, 32'h33,     2'd1, 1);
        add(0, 0, 0, 5'd0, 32'h0,       2'd0, 1,   0, 1, 5'd3, 32'h33,     2'd1, 0);
        // back-pressure fills the skid, then drains in order
        add(0, 0, 1, 5'd4, 32'hA,       2'd0, 0,   1, 1, 5'd4, 32'hA,      2'd0, 0);
        add(0, 0, 1, 5'd6, 32'hB,       2'd1, 0,   1, 0, 5'd4, 32'hA,      2'd0, 0);
        add(0, 0, 1, 5'd7, 32'hEE,      2'd1, 0,   1, 0, 5'd4, 32'hA,      2'd0, 0);
        add(0, 0, 0, 5'd0, 32'h0,       2'd0, 1,   1, 1, 5'd6, 32'hB,      2'd1, 1);
        add(0, 0, 0, 5'd0, 32'h0,       2'd0, 1,   0, 1, 5'd6, 32'hB,      2'd1, 0);
        // flush while FULL with an entry offered
        add(0, 0, 1, 5'd7, 32'h1,       2'd1, 0,   1, 1, 5'd7, 32'h1,      2'd1, 1);
        add(0, 0, 1, 5'd8, 32'h2,       2'd1, 0,   1, 0, 5'd7, 32'h1,      2'd1, 1);
        add(0, 1, 1, 5'd9, 32'hC,       2'd1, 0,   0, 1, 5'd7, 32'h1,      2'd1, 0);
        add(0, 0, 0, 5'd0, 32'h0,       2'd0, 1,   0, 1, 5'd7, 32'h1,      2'd1, 0);
        // forwarding tap
        add(0, 0, 1, 5'd5, 32'hDEAD,    2'd1, 1,   1, 1, 5'd5, 32'hDEAD,   2'd1, 1);
        add(0, 0, 1, 5'd0, 32'hDEAD,    2'd1, 1,   1, 1, 5'd0, 32'hDEAD,   2'd1, 0);
        add(0, 0, 1, 5'd5, 32'hDEAD,    2'd0, 1,   1, 1, 5'd5, 32'hDEAD,   2'd0, 0);
        add(0, 0, 1, 5'd5, 32'hBEEF,    2'd3, 1,   1, 1, 5'd5, 32'hBEEF,   2'd3, 1);
        // flush in ONE with simultaneous in_fire and out_fire
        add(0, 1, 1, 5'd1, 32'h77,      2'd1, 1,   0, 1, 5'd5, 32'hBEEF,   2'd3, 0);
        // ONE with simultaneous accept and deliver
        add(0, 0, 1, 5'd8, 32'h100,     2'd0, 0,   1, 1, 5'd8, 32'h100,    2'd0, 0);
        add(0, 0, 1, 5'd9, 32'h200,     2'd1, 1,   1, 1, 5'd9, 32'h200,    2'd1, 1);
        add(0, 0, 0, 5'd0, 32'h0,       2'd0, 0,   1, 1, 5'd9, 32'h200,    2'd1, 1);
        // reset mid-transfer from FULL
        add(0, 0, 1, 5'd3, 32'h300,     2'd1, 0,   1, 0, 5'd9, 32'h200,    2'd1, 1);
        add(1, 0, 1, 5'd3, 32'h400,     2'd1, 0,   0, 0, 5'd0, 32'h0,      2'd0, 0);
        add(0, 0, 0, 5'd0, 32'h0,       2'd0, 1,   0, 1, 5'd0, 32'h0,      2'd0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst = vq[i].rst; flush = vq[i].flush; in_valid = vq[i].iv;
            in_rd_addr = vq[i].ird; in_data = vq[i].idat; in_ctrl = vq[i].ictl;
            out_ready = vq[i].ordy;
            @(posedge clk);
            #1;
            chk("out_valid",   i, {31'd0, out_valid}, {31'd0, vq[i].e_ov});
            chk("in_ready",    i, {31'd0, in_ready},  {31'd0, vq[i].e_ir});
            chk("out_rd_addr", i, {27'd0, out_rd_addr}, {27'd0, vq[i].e_rd});
            chk("out_data",    i, out_data, vq[i].e_dat);
            chk("out_ctrl",    i, {30'd0, out_ctrl}, {30'd0, vq[i].e_ctl});
            chk("fwd_hit",     i, {31'd0, fwd_hit}, {31'd0, vq[i].e_fwd});
            chk("fwd_rd_addr", i, {27'd0, fwd_rd_addr}, {27'd0, vq[i].e_rd});
            chk("fwd_data",    i, fwd_data, vq[i].e_dat);
        end

        // Random handshake run against a reference queue (depth 2).
        seq = 32'h1000;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            rst = 1'b0;
            in_valid = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            flush = ($urandom_range(0, 99) < 5);
            in_data = seq;
            in_rd_addr = seq[4:0];
            in_ctrl = seq[1:0];
            #1;
            chk("rnd_out_valid", c, {31'd0, out_valid}, {31'd0, ref_q.size() != 0});
            chk("rnd_in_ready",  c, {31'd0, in_ready},  {31'd0, ref_q.size() < 2});
            fi = in_valid && (ref_q.size() < 2);
            fo = out_ready && (ref_q.size() != 0);
            if (fo) begin
                exp_d = ref_q.pop_front();
                chk("rnd_order", c, out_data, exp_d);
            end
            if (flush) begin
                ref_q.delete();
            end else if (fi) begin
                ref_q.push_back(seq);
            end
            if (fi) seq++;
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
